// File: rtl/fifo_channel.sv
`default_nettype none
// ============================================================================
// Module      : fifo_channel
// Description : Single first-word-fall-through FIFO with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_channel #(
    parameter int o = 8,
    parameter int d = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [o-1:0] data,
    input  logic         cke,
    output logic         full,
    output logic         overflow,
    input  logic         ovf_clr,
    output logic [o-1:0] out,
    output logic         rdy,
    input  logic         pop
);

    localparam int c_AW = (d > 1) ? $clog2(d) : 1;
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(d);

    logic [o-1:0]    r_mem [d];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;

    logic w_push;
    logic w_pop;
    logic w_ovf;

    assign rdy  = (r_count != '0);
    assign full = (r_count == c_DEPTH);

    // A pop on a full FIFO frees the slot the push needs in the same cycle.
    assign w_push = cke && (!full || pop);
    assign w_pop  = pop && rdy;
    assign w_ovf  = cke && full && !pop;

    assign out      = r_mem[r_rd_ptr];
    assign overflow = r_overflow;

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // A fresh overflow takes priority over a clear on the same edge.
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bank
// Description : Bank of n independent FWFT FIFOs sharing one write-data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bank #(
    parameter int n = 8,
    parameter int o = 8,
    parameter int d = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [o-1:0]   data,
    input  logic [n-1:0]   cke,
    output logic [n-1:0]   full,
    output logic [n-1:0]   overflow,
    input  logic [n-1:0]   ovf_clr,
    output logic [n*o-1:0] out,
    output logic [n-1:0]   rdy,
    input  logic [n-1:0]   pop
);

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_chan
            fifo_channel #(
                .o (o),
                .d (d)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .data     (data),
                .cke      (cke[gi]),
                .full     (full[gi]),
                .overflow (overflow[gi]),
                .ovf_clr  (ovf_clr[gi]),
                .out      (out[gi*o +: o]),
                .rdy      (rdy[gi]),
                .pop      (pop[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_bank
// Description : Directed self-checking bench for fifo_bank (n=4, o=8, d=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_bank;

    localparam int c_N = 4;
    localparam int c_O = 8;
    localparam int c_D = 4;

    logic               clk;
    logic               rst;
    logic [c_O-1:0]     data;
    logic [c_N-1:0]     cke;
    logic [c_N-1:0]     full;
    logic [c_N-1:0]     overflow;
    logic [c_N-1:0]     ovf_clr;
    logic [c_N*c_O-1:0] out;
    logic [c_N-1:0]     rdy;
    logic [c_N-1:0]     pop;

    int checks   = 0;
    int failures = 0;

    fifo_bank #(
        .n (c_N),
        .o (c_O),
        .d (c_D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .cke      (cke),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .out      (out),
        .rdy      (rdy),
        .pop      (pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs then return idle.
    task automatic tick();
        @(posedge clk);
        #1;
        cke     = '0;
        pop     = '0;
        ovf_clr = '0;
    endtask

    task automatic push(input logic [c_N-1:0] sel, input logic [7:0] val);
        cke  = sel;
        data = val;
        tick();
    endtask

    initial begin
        rst = 1'b1; data = '0; cke = '0; pop = '0; ovf_clr = '0;
        #12;
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle_rdy_%0d", i), 32'(rdy), 32'h0);
            check($sformatf("idle_full_%0d", i), 32'(full), 32'h0);
            check($sformatf("idle_ovf_%0d", i), 32'(overflow), 32'h0);
            tick();
        end

        // Fill and drain FIFO 0
        for (int k = 0; k < 4; k++) begin
            push(4'b0001, 8'(8'h11 * (k + 1)));
            check($sformatf("fill0_full_%0d", k), 32'(full), (k == 3) ? 32'h1 : 32'h0);
            check($sformatf("fill0_rdy_%0d", k), 32'(rdy), 32'h1);
        end
        check("fill0_head", 32'(out[7:0]), 32'h11);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain0_out_%0d", k), 32'(out[7:0]), 32'(8'h11 * (k + 1)));
            pop = 4'b0001;
            tick();
        end
        check("drain0_rdy", 32'(rdy), 32'h0);
        check("drain0_full", 32'(full), 32'h0);

        // Broadcast to FIFOs 1 and 3
        push(4'b1010, 8'hA5);
        check("bc_rdy", 32'(rdy), 32'hA);
        check("bc_out1", 32'(out[15:8]), 32'hA5);
        check("bc_out3", 32'(out[31:24]), 32'hA5);
        pop = 4'b0010;
        tick();
        check("bc_pop1_rdy", 32'(rdy), 32'h8);
        check("bc_out3_kept", 32'(out[31:24]), 32'hA5);
        pop = 4'b1000;
        tick();
        check("bc_pop3_rdy", 32'(rdy), 32'h0);

        // Overflow on FIFO 2
        for (int k = 0; k < 4; k++) push(4'b0100, 8'(8'hC1 + k));
        check("ovf_full", 32'(full), 32'h4);
        check("ovf_pre", 32'(overflow), 32'h0);
        push(4'b0100, 8'h99);
        check("ovf_set", 32'(overflow), 32'h4);
        check("ovf_full_after", 32'(full), 32'h4);
        tick();
        check("ovf_sticky", 32'(overflow), 32'h4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_drain_%0d", k), 32'(out[23:16]), 32'(8'hC1 + k));
            pop = 4'b0100;
            tick();
        end
        check("ovf_drain_rdy", 32'(rdy), 32'h0);
        check("ovf_still_set", 32'(overflow), 32'h4);
        ovf_clr = 4'b0100;
        tick();
        check("ovf_clr", 32'(overflow), 32'h0);

        // Set-wins and full push+pop on FIFO 1
        for (int k = 0; k < 4; k++) push(4'b0010, 8'(8'hD0 + k));
        check("f1_full", 32'(full), 32'h2);
        ovf_clr = 4'b0010;
        push(4'b0010, 8'hEE);
        check("setwins_ovf", 32'(overflow), 32'h2);
        ovf_clr = 4'b0010;
        tick();
        check("setwins_clr", 32'(overflow), 32'h0);
        check("fpp_head_pre", 32'(out[15:8]), 32'hD0);
        pop = 4'b0010;
        push(4'b0010, 8'hE0);
        check("fpp_full", 32'(full), 32'h2);
        check("fpp_ovf", 32'(overflow), 32'h0);
        check("fpp_head", 32'(out[15:8]), 32'hD1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fpp_drain_%0d", k), 32'(out[15:8]), (k == 3) ? 32'hE0 : 32'(8'hD1 + k));
            pop = 4'b0010;
            tick();
        end
        check("fpp_drain_rdy", 32'(rdy), 32'h0);

        // Empty push+pop on FIFO 3
        pop = 4'b1000;
        push(4'b1000, 8'h5A);
        check("epp_rdy", 32'(rdy), 32'h8);
        check("epp_out", 32'(out[31:24]), 32'h5A);
        pop = 4'b1000;
        tick();
        check("epp_one_word", 32'(rdy), 32'h0);

        // Pop while empty
        pop = 4'b1111;
        tick();
        check("pope_rdy", 32'(rdy), 32'h0);
        check("pope_ovf", 32'(overflow), 32'h0);
        check("pope_full", 32'(full), 32'h0);

        // Reset mid-operation
        push(4'b0001, 8'h01);
        push(4'b0001, 8'h02);
        check("mid_rdy_pre", 32'(rdy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rdy_async", 32'(rdy), 32'h0);
        check("mid_full_async", 32'(full), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        push(4'b0001, 8'h77);
        check("mid_post_out", 32'(out[7:0]), 32'h77);
        check("mid_post_rdy", 32'(rdy), 32'h1);
        pop = 4'b0001;
        tick();
        check("mid_post_empty", 32'(rdy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_bank.md
# fifo_bank

Bank of `n` independent first-word-fall-through FIFOs that share one write-data bus and have a separate write enable per FIFO. It sits directly downstream of the data matrix. The matrix drives the shared data word and one clock-enable bit per output. Each FIFO's read side offers a ready/pop interface to a per-port consumer, such as a UART transmitter. Overflow is detected per FIFO and reported sticky.

## Interface
Parameters:
- `n`, 8, number of FIFOs (output ports)
- `o`, 8, data width in bits
- `d`, 16, depth per FIFO in words; power of two, ≥2

Ports:
- `clk`  in  1  master clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `data`  in  o  shared write word, sampled on every edge where any `cke` bit is set
- `cke`  in  n  per-FIFO write enable; bit i pushes `data` into FIFO i
- `full`  out  n  FIFO i holds `d` words
- `overflow`  out  n  sticky; set when a push hits a full FIFO without a simultaneous pop
- `ovf_clr`  in  n  per-FIFO synchronous clear of `overflow`
- `out`  out  n*o  head word of each FIFO; FIFO i occupies bits [(i+1)*o-1 : i*o]
- `rdy`  out  n  FIFO i non-empty; `out` slice i is valid
- `pop`  in  n  consumer removes the head of FIFO i

## Operation
- Each FIFO keeps:
  - a write pointer and a read pointer, each $clog2(d) bits, wrapping modulo `d`;
  - an occupancy counter of $clog2(d)+1 bits, range 0..d.
- `rdy[i]` = (count != 0). `full[i]` = (count == d). Both are decoded from registered state.
- `out` slice i = mem_i[rd_ptr]: a combinational read of storage, so FWFT. It is don't-care while `rdy[i]`=0.
- Push accepted when `cke[i]` && (!full[i] || pop[i]).
- Pop accepted when `pop[i]` && rdy[i].
- Accepted push: write word, advance write pointer. Accepted pop: advance read pointer.
- Count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Boundary decisions:
  - Full FIFO with simultaneous push and pop: both accepted, count stays at `d`, no overflow.
  - Empty FIFO with simultaneous push and pop: pop ignored, push accepted, count becomes 1.
  - Pop while empty: ignored, no error flag.
  - Push rejected on full: word dropped, `overflow[i]` set on that edge.
  - `ovf_clr[i]` and a new overflow on the same edge: set wins.
- Channels are fully independent. Several `cke` bits may be set on one edge; every selected FIFO stores the same `data`.
- Reset (asynchronous, any time, including mid-transfer): all pointers and counts go to 0.
  - Reset values: `rdy`=0, `full`=0, `overflow`=0, `out` don't-care.
  - Storage contents are not cleared.
  - In-flight words are lost.

## Timing
- Push on edge t → `rdy[i]` high and `out` valid from just after edge t. Write-to-read latency is one cycle.
- Pop on edge t → the next word, or `rdy`=0, appears just after edge t. Back-to-back pops every cycle are legal.
- `full`/`overflow` change only on clock edges or on reset assertion.
- `rst` is asynchronous on assertion. Release is assumed synchronised outside the block. The first accepted push is on the first edge with `rst` low.
- Sustained throughput: one push and one pop per FIFO per cycle.

## Structure
- Sub-module `fifo_channel`: one FIFO with parameters `o` and `d`, and ports clk, rst, data, cke, full, overflow, ovf_clr, out, rdy, pop.
- `fifo_bank` is a generate loop of `n` instances:
  - shared `data`;
  - bit-sliced `cke`/`pop`/`ovf_clr`/`rdy`/`full`/`overflow`;
  - `out` packed as above.
- No shared package is needed. Pointer and count widths derive locally from `d` via $clog2.
- Storage is a plain register array per channel, inferable as iCE40 BRAM or LUT RAM.

## Test plan
Bench parameters: n=4, o=8, d=4.
- Reset then idle → `rdy`=0000, `full`=0000, `overflow`=0000 for 10 cycles.
- Fill and drain FIFO 0:
  - stimulus: `cke`=0001 with data 0x11, 0x22, 0x33, 0x44 on four edges;
  - expect: `full[0]`=1 after the 4th edge;
  - then pop four times → `out[7:0]` reads 0x11, 0x22, 0x33, 0x44, and `rdy[0]`=0 after the last pop.
- Broadcast:
  - stimulus: `cke`=1010, data 0xA5;
  - expect: `rdy`=1010, slices 1 and 3 = 0xA5;
  - then pop FIFO 1 only → `rdy`=1000.
- Overflow:
  - stimulus: FIFO 2 full, push 0x99 with no pop;
  - expect: word dropped, `overflow[2]`=1 and sticky, then a drain reads the original 4 words;
  - then `ovf_clr[2]` → `overflow[2]`=0.
- Simultaneous push and pop:
  - on a full FIFO → count stays at 4, `overflow`=0, head advances;
  - on an empty FIFO with push 0x5A → `rdy`=1, `out`=0x5A.
- Reset mid-operation:
  - stimulus: FIFO 0 holds 2 words, assert `rst` between edges;
  - expect: `rdy[0]` drops immediately;
  - after release, push 0x77 → `out[7:0]`=0x77 as the first word.
